// File: rtl/version_store_if.sv
// Write-side bus of version_store.
//
// Purpose: groups the write handshake so the producer and the store share
// one bundle.
//
// Handshake: a write is transferred on a rising edge where writeValid and
// writeReady are both high. While writeValid is high the producer holds
// writeData stable until that edge. writeReady may change combinationally
// with store state and minActiveVersion and never depends on writeValid.
// writeVersion is the version a write transferred in this cycle receives.
//
// Signals:
//   writeValid    master -> slave  write request
//   writeData     master -> slave  32-bit data to store
//   writeReady    slave  -> master store accepts this cycle
//   writeVersion  slave  -> master version stamped on the accepted write
interface version_store_if #(
  parameter int BLOCK_SIZE = 4
);
  logic                  writeValid;
  logic [31:0]           writeData;
  logic                  writeReady;
  logic [BLOCK_SIZE-1:0] writeVersion;

  modport master (
    output writeValid, writeData,
    input  writeReady, writeVersion
  );

  modport slave (
    input  writeValid, writeData,
    output writeReady, writeVersion
  );
endinterface

// File: rtl/version_store.sv
// Four-slot multi-version store for one 32-bit object.
//
// Purpose: every accepted write is stamped with a monotonically increasing
// version and placed in an empty slot, or failing that in the oldest slot
// that no reader can still request. All four (version, data) pairs are
// registered outputs. Version 0 marks an empty slot.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wr                  write handshake bus (slave side)
//   minActiveVersion    slots with a nonzero version below this are reclaimable
//   rebase              one-cycle pulse requesting an epoch rebase
//   version0..3         registered slot versions (0 = empty)
//   dataOut0..3         registered slot data
//   nextVersion         version the next accepted write receives
//   exhausted           version space used up, waiting for rebase
//   state_dbg           current FSM state (0 NORMAL, 1 EXHAUSTED, 2 REBASE)
module version_store #(
  parameter int BLOCK_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  version_store_if.slave        wr,
  input  logic [BLOCK_SIZE-1:0] minActiveVersion,
  input  logic                  rebase,
  output logic [BLOCK_SIZE-1:0] version0,
  output logic [BLOCK_SIZE-1:0] version1,
  output logic [BLOCK_SIZE-1:0] version2,
  output logic [BLOCK_SIZE-1:0] version3,
  output logic [31:0]           dataOut0,
  output logic [31:0]           dataOut1,
  output logic [31:0]           dataOut2,
  output logic [31:0]           dataOut3,
  output logic [BLOCK_SIZE-1:0] nextVersion,
  output logic                  exhausted,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_EXHAUSTED = 2'd1,
    ST_REBASE    = 2'd2
  } state_t;

  localparam logic [BLOCK_SIZE-1:0] MAX_VER = '1;
  localparam logic [BLOCK_SIZE-1:0] ONE_VER = BLOCK_SIZE'(1);
  localparam logic [BLOCK_SIZE-1:0] TWO_VER = BLOCK_SIZE'(2);

  state_t                state_q, state_d;
  logic [BLOCK_SIZE-1:0] ver_q [4];
  logic [BLOCK_SIZE-1:0] ver_d [4];
  logic [31:0]           dat_q [4];
  logic [31:0]           dat_d [4];
  logic [BLOCK_SIZE-1:0] next_q, next_d;

  // Slot survey
  logic                  found_empty;
  logic [1:0]            empty_idx;
  logic                  any_nz;
  logic [BLOCK_SIZE-1:0] min_ver;
  logic [1:0]            min_idx;
  logic [BLOCK_SIZE-1:0] max_ver;
  logic [1:0]            max_idx;
  logic                  reclaim_ok;
  logic                  target_valid;
  logic [1:0]            target_idx;
  logic                  write_ready;
  logic                  accept;

  always_comb begin
    found_empty = 1'b0;
    empty_idx   = 2'd0;
    any_nz      = 1'b0;
    min_ver     = '1;
    min_idx     = 2'd0;
    max_ver     = '0;
    max_idx     = 2'd0;
    // Scan downwards so the lowest-index empty slot wins.
    for (int i = 3; i >= 0; i--) begin
      if (ver_q[i] == '0) begin
        found_empty = 1'b1;
        empty_idx   = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ver_q[i] != '0) begin
        if (!any_nz || (ver_q[i] < min_ver)) begin
          min_ver = ver_q[i];
          min_idx = 2'(i);
        end
        if (ver_q[i] > max_ver) begin
          max_ver = ver_q[i];
          max_idx = 2'(i);
        end
        any_nz = 1'b1;
      end
    end
    // The newest version is never reclaimed, so a reader always has one.
    // minActiveVersion of 0 or 1 makes this false since min_ver >= 1.
    reclaim_ok   = any_nz && (min_ver < minActiveVersion) && (min_idx != max_idx);
    target_valid = found_empty || reclaim_ok;
    target_idx   = found_empty ? empty_idx : min_idx;
    write_ready  = (state_q == ST_NORMAL) && target_valid;
    accept       = wr.writeValid && write_ready;
  end

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    for (int i = 0; i < 4; i++) begin
      ver_d[i] = ver_q[i];
      dat_d[i] = dat_q[i];
    end
    unique case (state_q)
      ST_NORMAL: begin
        if (accept) begin
          ver_d[target_idx] = next_q;
          dat_d[target_idx] = wr.writeData;
          if (next_q == MAX_VER) begin
            state_d = ST_EXHAUSTED;
          end else begin
            next_d = next_q + ONE_VER;
          end
        end
        // The write of this cycle is stored first, so it becomes the
        // newest entry that the rebase keeps.
        if (rebase) begin
          state_d = ST_REBASE;
        end
      end
      ST_EXHAUSTED: begin
        if (rebase) begin
          state_d = ST_REBASE;
        end
      end
      ST_REBASE: begin
        for (int i = 0; i < 4; i++) begin
          if (any_nz && (2'(i) == max_idx)) begin
            ver_d[i] = ONE_VER;
          end else begin
            ver_d[i] = '0;
            dat_d[i] = '0;
          end
        end
        next_d  = any_nz ? TWO_VER : ONE_VER;
        state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      next_q  <= ONE_VER;
      for (int i = 0; i < 4; i++) begin
        ver_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      for (int i = 0; i < 4; i++) begin
        ver_q[i] <= ver_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign wr.writeReady   = write_ready;
  assign wr.writeVersion = next_q;
  assign version0        = ver_q[0];
  assign version1        = ver_q[1];
  assign version2        = ver_q[2];
  assign version3        = ver_q[3];
  assign dataOut0        = dat_q[0];
  assign dataOut1        = dat_q[1];
  assign dataOut2        = dat_q[2];
  assign dataOut3        = dat_q[3];
  assign nextVersion     = next_q;
  assign exhausted       = (state_q == ST_EXHAUSTED);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_version_store.sv
module tb_version_store;

  localparam int BS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  version_store_if #(.BLOCK_SIZE(BS)) wr_if ();

  logic [BS-1:0] min_active;
  logic          rebase;
  logic [BS-1:0] version0, version1, version2, version3;
  logic [31:0]   dataOut0, dataOut1, dataOut2, dataOut3;
  logic [BS-1:0] next_version;
  logic          exhausted;
  logic [1:0]    state_dbg;

  version_store #(.BLOCK_SIZE(BS)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr               (wr_if),
    .minActiveVersion (min_active),
    .rebase           (rebase),
    .version0         (version0),
    .version1         (version1),
    .version2         (version2),
    .version3         (version3),
    .dataOut0         (dataOut0),
    .dataOut1         (dataOut1),
    .dataOut2         (dataOut2),
    .dataOut3         (dataOut3),
    .nextVersion      (next_version),
    .exhausted        (exhausted),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Entry: {slot index[1:0], version[3:0], data[31:0]}
  logic [37:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference copy of the slots as the bench expects them.
  logic [BS-1:0] m_ver [4];
  logic [31:0]   m_dat [4];
  logic [BS-1:0] m_next;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BS-1:0] obs_ver(input int idx);
    case (idx)
      0: return version0;
      1: return version1;
      2: return version2;
      default: return version3;
    endcase
  endfunction

  function automatic logic [31:0] obs_dat(input int idx);
    case (idx)
      0: return dataOut0;
      1: return dataOut1;
      2: return dataOut2;
      default: return dataOut3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_ver[i] = '0;
      m_dat[i] = '0;
    end
    m_next = 4'd1;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_ver%0d", tag, i), 64'(obs_ver(i)), 64'(m_ver[i]));
      check($sformatf("%s_dat%0d", tag, i), 64'(obs_dat(i)), 64'(m_dat[i]));
    end
    check($sformatf("%s_next", tag), 64'(next_version), 64'(m_next));
  endtask

  // ---------------- driver ----------------
  // Drives one write expected to be accepted into slot exp_idx as exp_ver.
  task automatic do_write(input logic [31:0] data, input int exp_idx,
                          input logic [BS-1:0] exp_ver, input logic rb);
    logic [37:0] e;
    wr_if.writeValid = 1'b1;
    wr_if.writeData  = data;
    rebase           = rb;
    #1;
    check("wr_ready", 64'(wr_if.writeReady), 64'd1);
    check("wr_version", 64'(wr_if.writeVersion), 64'(exp_ver));
    exp_q.push_back({2'(exp_idx), exp_ver, data});
    tick();
    wr_if.writeValid = 1'b0;
    rebase           = 1'b0;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_ver", 64'(obs_ver(int'(e[37:36]))), 64'(e[35:32]));
      check("sb_dat", 64'(obs_dat(int'(e[37:36]))), 64'(e[31:0]));
      m_ver[e[37:36]] = e[35:32];
      m_dat[e[37:36]] = e[31:0];
    end
    if (exp_ver != 4'd15) m_next = exp_ver + 4'd1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    wr_if.writeValid = 1'b0;
    wr_if.writeData  = '0;
    min_active       = 4'd1;
    rebase           = 1'b0;
    model_clear();

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_model("reset");
    check("reset_exh", 64'(exhausted), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    check("reset_ready", 64'(wr_if.writeReady), 64'd1);

    // Fill the four empty slots in order.
    for (int i = 0; i < 4; i++) do_write(32'hA0 + 32'(i), i, 4'(i + 1), 1'b0);
    check_model("fill");

    // Full, nothing reclaimable.
    wr_if.writeValid = 1'b1;
    wr_if.writeData  = 32'hB0;
    #1;
    check("full_ready", 64'(wr_if.writeReady), 64'd0);
    tick();
    check_model("full_hold");

    // Versions 1,2 become reclaimable; version 1 is the smallest.
    min_active = 4'd3;
    do_write(32'hB0, 0, 4'd5, 1'b0);

    // Slots now 5,2,3,4. Smallest below 4 is version 2 in slot 1, then 3.
    min_active = 4'd4;
    do_write(32'hC1, 1, 4'd6, 1'b0);
    do_write(32'hD2, 2, 4'd7, 1'b0);
    // Only version 4 remains as candidate and it is not below 4.
    #1;
    check("min_bound_ready", 64'(wr_if.writeReady), 64'd0);
    check_model("min_bound");

    // Run the version space up to 15, always replacing the oldest slot.
    min_active = 4'd15;
    for (int v = 8; v <= 15; v++) begin
      idx = 0;
      for (int i = 1; i < 4; i++) if (m_ver[i] < m_ver[idx]) idx = i;
      do_write(32'h100 + 32'(v), idx, 4'(v), 1'b0);
    end
    check("exh_flag", 64'(exhausted), 64'd1);
    check("exh_state", 64'(state_dbg), 64'd1);
    wr_if.writeValid = 1'b1;
    wr_if.writeData  = 32'hEE;
    #1;
    check("exh_ready", 64'(wr_if.writeReady), 64'd0);
    tick();
    wr_if.writeValid = 1'b0;
    check_model("exh_hold");

    // Rebase held for two edges: the second pulse lands in REBASE and is ignored.
    rebase = 1'b1;
    tick();
    check("rb_state", 64'(state_dbg), 64'd2);
    check("rb_ready", 64'(wr_if.writeReady), 64'd0);
    tick();
    rebase = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_ver[i] == 4'd15) begin
        m_ver[i] = 4'd1;
      end else begin
        m_ver[i] = '0;
        m_dat[i] = '0;
      end
    end
    m_next = 4'd2;
    check_model("rebase");
    check("rebase_exh", 64'(exhausted), 64'd0);
    check("rebase_state", 64'(state_dbg), 64'd0);

    // Write and rebase together: the written value is the one kept.
    do_write(32'hCC, 0, 4'd2, 1'b1);
    check("wrb_state", 64'(state_dbg), 64'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      m_ver[i] = '0;
      m_dat[i] = '0;
    end
    m_ver[0] = 4'd1;
    m_dat[0] = 32'hCC;
    m_next   = 4'd2;
    check_model("wrb");

    // Reset while in REBASE.
    do_write(32'hE1, 1, 4'd2, 1'b0);
    rebase = 1'b1;
    tick();
    rebase = 1'b0;
    check("pre_rst_state", 64'(state_dbg), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check_model("rst_rebase");
    check("rst_rebase_state", 64'(state_dbg), 64'd0);
    check("rst_rebase_ready", 64'(wr_if.writeReady), 64'd1);

    // Rebase with every slot empty keeps nothing and restarts at 1.
    rebase = 1'b1;
    tick();
    rebase = 1'b0;
    tick();
    check_model("empty_rebase");
    check("empty_rebase_state", 64'(state_dbg), 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
